// File: rtl/map_table.sv
// Register alias table: maps architectural registers to ROB tags for a
// two-wide dispatch group. Tracks ready-in-ROB by snooping both CDBs and
// drops mappings on retire or on a mispredict flush.
module map_table #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned IDX_BITS = 5
) (
    input  logic       clock,
    input  logic       reset,

    input  logic       inst1_valid_in,
    input  logic [4:0] inst1_dest_in,
    input  logic [4:0] inst1_rega_in,
    input  logic [4:0] inst1_regb_in,
    input  logic [7:0] inst1_tag_in,

    input  logic       inst2_valid_in,
    input  logic [4:0] inst2_dest_in,
    input  logic [4:0] inst2_rega_in,
    input  logic [4:0] inst2_regb_in,
    input  logic [7:0] inst2_tag_in,

    input  logic [7:0] cdb1_tag_in,
    input  logic [7:0] cdb2_tag_in,

    input  logic [4:0] retire1_dest_in,
    input  logic [7:0] retire1_tag_in,
    input  logic [4:0] retire2_dest_in,
    input  logic [7:0] retire2_tag_in,

    input  logic       flush_in,

    output logic [7:0] inst1_rega_tag_out,
    output logic [7:0] inst1_regb_tag_out,
    output logic [7:0] inst2_rega_tag_out,
    output logic [7:0] inst2_regb_tag_out
);

    localparam logic [7:0] NO_TAG   = 8'hFF;
    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam int         PAD_BITS = 7 - IDX_BITS;

    // Per-register mapping state
    logic [NUM_REGS-1:0] valid_q, valid_d;
    logic [NUM_REGS-1:0] ready_q, ready_d;
    logic [IDX_BITS-1:0] idx_q [NUM_REGS];
    logic [IDX_BITS-1:0] idx_d [NUM_REGS];

    // Combinational view of each entry including same-cycle CDB forwarding
    logic [NUM_REGS-1:0] cdb_hit;
    logic [7:0]          entry_tag [NUM_REGS];

    logic       cdb1_active, cdb2_active;
    logic       wr1, wr2;
    logic       rt1, rt2;
    logic       fwd_ok;
    logic [7:0] fwd_tag;

    assign cdb1_active = (cdb1_tag_in != NO_TAG);
    assign cdb2_active = (cdb2_tag_in != NO_TAG);

    // A dispatch only creates a mapping when it has both a real dest and a real tag
    assign wr1 = inst1_valid_in && (inst1_dest_in != ZERO_REG) && (inst1_tag_in != NO_TAG);
    assign wr2 = inst2_valid_in && (inst2_dest_in != ZERO_REG) && (inst2_tag_in != NO_TAG);

    assign rt1 = (retire1_tag_in != NO_TAG) && (retire1_dest_in != ZERO_REG);
    assign rt2 = (retire2_tag_in != NO_TAG) && (retire2_dest_in != ZERO_REG);

    // Slot 2 reads slot 1's fresh mapping; the producer cannot be done yet
    assign fwd_ok  = inst1_valid_in && (inst1_dest_in != ZERO_REG);
    assign fwd_tag = {1'b0, inst1_tag_in[6:0]};

    // Build the lookup value of every entry from current state plus CDB snoop
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cdb_hit[i] = valid_q[i] &&
                         ((cdb1_active && (idx_q[i] == cdb1_tag_in[IDX_BITS-1:0])) ||
                          (cdb2_active && (idx_q[i] == cdb2_tag_in[IDX_BITS-1:0])));
            if (i == 0 || !valid_q[i]) begin
                entry_tag[i] = NO_TAG;
            end else begin
                entry_tag[i] = {ready_q[i] | cdb_hit[i], {PAD_BITS{1'b0}}, idx_q[i]};
            end
        end
    end

    // Source lookups; slot 1 never sees slot 2's destination
    always_comb begin
        inst1_rega_tag_out = entry_tag[inst1_rega_in];
        inst1_regb_tag_out = entry_tag[inst1_regb_in];

        if (fwd_ok && (inst2_rega_in == inst1_dest_in)) begin
            inst2_rega_tag_out = fwd_tag;
        end else begin
            inst2_rega_tag_out = entry_tag[inst2_rega_in];
        end

        if (fwd_ok && (inst2_regb_in == inst1_dest_in)) begin
            inst2_regb_tag_out = fwd_tag;
        end else begin
            inst2_regb_tag_out = entry_tag[inst2_regb_in];
        end
    end

    // Next state: later assignments win, giving dispatch > retire > CDB
    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            idx_d[i] = idx_q[i];
        end

        for (int i = 1; i < NUM_REGS; i++) begin
            if (cdb_hit[i]) begin
                ready_d[i] = 1'b1;
            end

            // A retire only clears the entry if it still names that producer
            if ((rt1 && (retire1_dest_in == 5'(i)) && valid_q[i] &&
                 (idx_q[i] == retire1_tag_in[IDX_BITS-1:0])) ||
                (rt2 && (retire2_dest_in == 5'(i)) && valid_q[i] &&
                 (idx_q[i] == retire2_tag_in[IDX_BITS-1:0]))) begin
                valid_d[i] = 1'b0;
                ready_d[i] = 1'b0;
            end

            if (wr2 && (inst2_dest_in == 5'(i))) begin
                valid_d[i] = 1'b1;
                ready_d[i] = 1'b0;
                idx_d[i]   = inst2_tag_in[IDX_BITS-1:0];
            end else if (wr1 && (inst1_dest_in == 5'(i))) begin
                valid_d[i] = 1'b1;
                ready_d[i] = 1'b0;
                idx_d[i]   = inst1_tag_in[IDX_BITS-1:0];
            end
        end

        // Flush discards everything else happening this cycle
        if (flush_in) begin
            valid_d = '0;
            ready_d = '0;
        end
    end

    // Mapping state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            ready_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

endmodule
